// File: rtl/ifetch_axil_bridge_pkg.sv
// Shared widths, AXI response codes and constants for the instruction-fetch bridge.
package ifetch_axil_bridge_pkg;

  localparam int unsigned AXI_ADDR_BUS  = 32;
  localparam int unsigned AXI_DATA_BUS  = 32;
  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_DATA_BUS = 32;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // MIPS NOP substituted when the slave reports an error.
  localparam logic [INST_DATA_BUS-1:0] ERR_INST = 32'h0000_0000;
  // Instruction access, unprivileged, secure.
  localparam logic [2:0] AR_PROT = 3'b100;

  function automatic logic resp_is_ok(input logic [1:0] resp);
    return resp == AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifetch_axil_bridge_if.sv
// AXI-Lite read-only channel bundle (AR + R) between the fetch bridge and the interconnect.
interface ifetch_axil_bridge_if;
  import ifetch_axil_bridge_pkg::*;

  logic [AXI_ADDR_BUS-1:0] m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [AXI_DATA_BUS-1:0] m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;

  modport master (
    output m_araddr, m_arprot, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arprot, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );

endinterface

// File: rtl/ifetch_buf.sv
// One-entry instruction buffer: word address tag, data, valid flag and hit compare.
module ifetch_buf #(
  parameter int unsigned AddrW = 30,
  parameter int unsigned DataW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_en,
  input  logic [AddrW-1:0] fill_addr,
  input  logic [DataW-1:0] fill_data,
  input  logic             lookup_en,
  input  logic [AddrW-1:0] lookup_addr,
  output logic             hit,
  output logic [DataW-1:0] data
);

  logic             valid_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] data_q;

  // Buffer registers: cleared on reset, overwritten on every completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

  assign hit  = lookup_en && valid_q && (addr_q == lookup_addr);
  assign data = data_q;

endmodule

// File: rtl/ifetch_axil_bridge.sv
// Instruction-fetch bridge: turns core ROM fetches into single-beat AXI-Lite reads,
// serves hits from a one-entry buffer and stalls the core until the PC's word is present.
module ifetch_axil_bridge
  import ifetch_axil_bridge_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rom_ce_i,
  input  logic [INST_ADDR_BUS-1:0] rom_addr_i,
  output logic [INST_DATA_BUS-1:0] rom_data_o,
  output logic                     stall_req_o,
  output logic                     fetch_err_o,
  ifetch_axil_bridge_if.master     axi
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [AXI_ADDR_BUS-1:0] araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    fetch_err_q, fetch_err_d;

  logic                     hit;
  logic [INST_DATA_BUS-1:0] buf_data;
  logic                     fill_en;
  logic [INST_DATA_BUS-1:0] fill_data;

  // Byte offset within the word never selects anything; the buffer is word-tagged.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^rom_addr_i[1:0];

  ifetch_buf #(
    .AddrW (INST_ADDR_BUS - 2),
    .DataW (INST_DATA_BUS)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .fill_en     (fill_en),
    .fill_addr   (araddr_q[AXI_ADDR_BUS-1:2]),
    .fill_data   (fill_data),
    .lookup_en   (rom_ce_i),
    .lookup_addr (rom_addr_i[INST_ADDR_BUS-1:2]),
    .hit         (hit),
    .data        (buf_data)
  );

  // Next-state logic for the single-outstanding read FSM and its AXI drivers.
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    fetch_err_d = 1'b0;
    fill_en     = 1'b0;
    fill_data   = axi.m_rdata;
    case (state_q)
      StIdle: begin
        if (rom_ce_i && !hit) begin
          state_d   = StAddr;
          araddr_d  = {rom_addr_i[INST_ADDR_BUS-1:2], 2'b00};
          arvalid_d = 1'b1;
        end
      end
      StAddr: begin
        if (arvalid_q && axi.m_arready) begin
          state_d   = StData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StData: begin
        // The fill always lands, even if the PC moved meanwhile; IDLE re-checks the hit.
        if (axi.m_rvalid && rready_q) begin
          state_d  = StIdle;
          rready_d = 1'b0;
          fill_en  = 1'b1;
          if (!resp_is_ok(axi.m_rresp)) begin
            fill_data   = ERR_INST;
            fetch_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign axi.m_araddr  = araddr_q;
  assign axi.m_arprot  = AR_PROT;
  assign axi.m_arvalid = arvalid_q;
  assign axi.m_rready  = rready_q;

  assign rom_data_o  = hit ? buf_data : '0;
  assign stall_req_o = rom_ce_i && !hit;
  assign fetch_err_o = fetch_err_q;

endmodule

// File: tb/tb_ifetch_axil_bridge.sv
// Scoreboard bench for ifetch_axil_bridge: stimulus queues expected AR addresses and
// delivered instructions; a negedge monitor pops and compares as the DUT presents them.
module tb_ifetch_axil_bridge;
  import ifetch_axil_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic [31:0] rom_data;
  logic        stall;
  logic        fetch_err;

  ifetch_axil_bridge_if axi_if ();

  ifetch_axil_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce),
    .rom_addr_i  (rom_addr),
    .rom_data_o  (rom_data),
    .stall_req_o (stall),
    .fetch_err_o (fetch_err),
    .axi         (axi_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         ar_delay = 0;
  int         r_delay  = 0;
  logic [1:0] resp_cfg = 2'b00;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3401_0001;
      32'h0000_0004: return 32'h3C08_ABCD;
      32'h0000_0100: return 32'h2402_0100;
      32'h0000_0200: return 32'h2402_0200;
      default:       return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // AXI-Lite slave model with programmable AR / R wait cycles.
  initial begin
    int          s_phase;
    int          s_cnt;
    logic [31:0] s_addr;
    s_phase = 0;
    s_cnt   = 0;
    s_addr  = '0;
    axi_if.m_arready = 1'b0;
    axi_if.m_rvalid  = 1'b0;
    axi_if.m_rdata   = '0;
    axi_if.m_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        s_phase = 0;
        s_cnt   = 0;
        axi_if.m_arready = 1'b0;
        axi_if.m_rvalid  = 1'b0;
      end else begin
        if (axi_if.m_arready) begin
          axi_if.m_arready = 1'b0;
          s_phase = 1;
          s_cnt   = 0;
        end else if (axi_if.m_rvalid) begin
          axi_if.m_rvalid = 1'b0;
          s_phase = 0;
          s_cnt   = 0;
        end
        if (s_phase == 0 && axi_if.m_arvalid) begin
          if (s_cnt == ar_delay) begin
            s_addr = axi_if.m_araddr;
            axi_if.m_arready = 1'b1;
          end else begin
            s_cnt++;
          end
        end else if (s_phase == 1) begin
          if (s_cnt == r_delay) begin
            axi_if.m_rvalid = 1'b1;
            axi_if.m_rdata  = mem_word(s_addr);
            axi_if.m_rresp  = resp_cfg;
          end else begin
            s_cnt++;
          end
        end
      end
    end
  end

  // Monitor: AR handshakes, AR stability, deliveries with stall-run length, idle outputs.
  initial begin
    int          stall_run;
    logic        prev_hold;
    logic [31:0] prev_addr;
    exp_t        e;
    stall_run = 0;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_run = 0;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        chk("ar_hold_valid", {31'b0, axi_if.m_arvalid}, 32'd1);
        chk("ar_hold_addr", axi_if.m_araddr, prev_addr);
      end
      if (axi_if.m_arvalid && axi_if.m_arready) begin
        if (exp_ar_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ar got=%h want=none", axi_if.m_araddr);
        end else begin
          chk("ar_addr", axi_if.m_araddr, exp_ar_q.pop_front());
          chk("ar_prot", {29'b0, axi_if.m_arprot}, 32'h4);
        end
      end
      prev_hold = axi_if.m_arvalid && !axi_if.m_arready;
      prev_addr = axi_if.m_araddr;
      if (!rom_ce) begin
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_data", rom_data, 32'd0);
        chk("idle_err", {31'b0, fetch_err}, 32'd0);
      end else if (stall) begin
        stall_run++;
      end else begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery got=%h want=none", rom_data);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_data", rom_data, e.data);
          chk("deliver_stalls", stall_run, e.stalls);
          chk("deliver_err", {31'b0, fetch_err}, {31'b0, e.err});
        end
        stall_run = 0;
      end
    end
  end

  task automatic wait_delivery();
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("delivery_wait", {31'b0, stall}, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stalls,
                       input logic err, input int hold, input logic [31:0] ar,
                       input bit expect_ar);
    if (expect_ar) exp_ar_q.push_back(ar);
    exp_q.push_back('{data, stalls, err});
    for (int i = 0; i < hold; i++) exp_q.push_back('{data, 0, 1'b0});
    @(posedge clk);
    #1;
    rom_ce   = 1'b1;
    rom_addr = addr;
    wait_delivery();
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    rom_ce = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_arvalid", {31'b0, axi_if.m_arvalid}, 32'd0);
    chk("rst_rready", {31'b0, axi_if.m_rready}, 32'd0);
    chk("rst_araddr", axi_if.m_araddr, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    rom_ce = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Zero-wait miss: 3 stall cycles.
    fetch(32'hBFC0_0000, 32'h3401_0001, 3, 1'b0, 1, 32'hBFC0_0000, 1'b1);
    idle(2);

    // Same PC after reset, AR waits 2 and R waits 3: 8 stall cycles.
    do_reset();
    ar_delay = 2;
    r_delay  = 3;
    fetch(32'hBFC0_0000, 32'h3401_0001, 8, 1'b0, 1, 32'hBFC0_0000, 1'b1);
    idle(2);
    ar_delay = 0;
    r_delay  = 0;

    // Unaligned PC is word-aligned on AR; repeated PC hits with no new AR.
    fetch(32'h0000_0006, 32'h3C08_ABCD, 3, 1'b0, 4, 32'h0000_0004, 1'b1);
    idle(2);

    // SLVERR: NOP substituted, error pulse only on the first hit cycle.
    resp_cfg = 2'b10;
    fetch(32'h0000_0008, 32'h0000_0000, 3, 1'b1, 2, 32'h0000_0008, 1'b1);
    idle(2);
    resp_cfg = 2'b00;

    // Branch while in DATA: 0x100 fill completes, then a second AR for 0x200.
    r_delay = 3;
    exp_ar_q.push_back(32'h0000_0100);
    exp_ar_q.push_back(32'h0000_0200);
    exp_q.push_back('{32'h2402_0200, 12, 1'b0});
    @(posedge clk);
    #1;
    rom_ce   = 1'b1;
    rom_addr = 32'h0000_0100;
    n = 0;
    @(posedge clk);
    #1;
    while (!axi_if.m_rready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("branch_rready_seen", {31'b0, axi_if.m_rready}, 32'd1);
    rom_addr = 32'h0000_0200;
    wait_delivery();
    idle(2);
    r_delay = 0;

    // Reset while in ADDR: AR dropped, buffer (holding 0x200) invalidated, AR re-issued.
    ar_delay = 5;
    @(posedge clk);
    #1;
    rom_ce   = 1'b1;
    rom_addr = 32'h0000_0300;
    n = 0;
    @(posedge clk);
    #1;
    while (!axi_if.m_arvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_mid_arvalid_seen", {31'b0, axi_if.m_arvalid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ar_delay = 0;
    rom_addr = 32'h0000_0200;
    exp_ar_q.push_back(32'h0000_0200);
    exp_q.push_back('{32'h2402_0200, 3, 1'b0});
    @(negedge clk);
    chk("rst_mid_arvalid", {31'b0, axi_if.m_arvalid}, 32'd0);
    chk("rst_mid_rready", {31'b0, axi_if.m_rready}, 32'd0);
    chk("rst_mid_buf_invalid", {31'b0, stall}, 32'd1);
    wait_delivery();
    idle(2);

    // Buffered PC after idle: zero-latency hit, no AR.
    fetch(32'h0000_0200, 32'h2402_0200, 0, 1'b0, 2, 32'h0, 1'b0);
    idle(3);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_ar_drained", exp_ar_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_axil_bridge.md
# ifetch_axil_bridge

Instruction-fetch bridge between the core's ROM port and the SoC AXI-Lite interconnect. It converts the core's combinational `rom_ce`/`rom_addr` fetch request into single-beat AXI-Lite read transactions and returns `rom_data`. It holds a one-entry fetch buffer and raises a stall request to CTRL until data for the current PC is available. It sits directly upstream of the core's IF_ID stage, as the core's instruction source.

## Interface
- `ERR_INST`, 32'h0000_0000: instruction substituted on a non-OKAY read response (MIPS NOP).
- `AR_PROT`, 3'b100: constant driven on `m_arprot` (instruction, unprivileged, secure).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `rom_ce_i`  in  1  fetch enable from core PC.
- `rom_addr_i`  in  32  fetch address (PC) from core.
- `rom_data_o`  out  32  instruction to core IF_ID.
- `stall_req_o`  out  1  fetch stall request to CTRL.
- `fetch_err_o`  out  1  one-cycle pulse on a non-OKAY response.
- `m_araddr`  out  32  AXI-Lite read address.
- `m_arprot`  out  3  constant `AR_PROT`.
- `m_arvalid`  out  1  read address valid.
- `m_arready`  in  1  read address ready.
- `m_rdata`  in  32  read data.
- `m_rresp`  in  2  read response.
- `m_rvalid`  in  1  read data valid.
- `m_rready`  out  1  read data ready.
- No write channels. Instruction memory is read-only on this port.

## Operation
- Buffer: `buf_valid`, `buf_addr[31:2]`, `buf_data[31:0]`.
- Hit: `rom_ce_i && buf_valid && buf_addr == rom_addr_i[31:2]`.
- Outputs are combinational from the buffer and the inputs:
  - On a hit: `rom_data_o = buf_data`, `stall_req_o = 0`.
  - `rom_ce_i = 1` without a hit: `stall_req_o = 1`, `rom_data_o = 0`.
  - `rom_ce_i = 0`: `stall_req_o = 0`, `rom_data_o = 0`.
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR when `rom_ce_i` is high and there is no hit. On that edge, latch `m_araddr = {rom_addr_i[31:2],2'b00}` and set `m_arvalid = 1`.
  - ADDR -> DATA on `m_arvalid && m_arready`. On that edge, `m_arvalid <= 0` and `m_rready <= 1`.
  - DATA -> IDLE on `m_rvalid && m_rready`. On that edge:
    - `m_rready <= 0`.
    - `buf_addr <= m_araddr[31:2]`, `buf_valid <= 1`.
    - `buf_data <= m_rdata` if `m_rresp == OKAY`; otherwise `buf_data <= ERR_INST` and `fetch_err_o` pulses for the next cycle.
- AXI rules:
  - `m_arvalid` and `m_araddr` stay stable until `m_arready`.
  - `m_arvalid` never depends combinationally on `m_arready`.
  - At most one outstanding transaction.
- PC change mid-transaction (branch, or `rom_ce_i` drop): the transaction still completes and fills the buffer. The hit is then re-evaluated, and a mismatch starts a new fetch from IDLE.
- Reset values: FSM IDLE, `m_arvalid = 0`, `m_rready = 0`, `m_araddr = 0`, `buf_valid = 0`, `buf_addr = 0`, `buf_data = 0`, `fetch_err_o = 0`.
- Reset mid-transaction abandons the transaction. The SoC reset also resets the interconnect, so no orphan response arrives.

## Timing
- Miss detected in cycle N. `m_arvalid` high from N+1.
- With `m_arready` and `m_rvalid` each high on first assertion: handshakes at N+1 and N+2, buffer filled at the end of N+2.
- Hit and `stall_req_o = 0` in N+3, so the minimum miss penalty is 3 stall cycles. Each wait cycle on AR or R adds one cycle.
- Sequential PCs miss every fetch: 3 stalls per instruction at zero wait. A repeated PC (pipeline stalled by ID/EX) hits with zero latency.
- `fetch_err_o` is registered and asserted in the same cycle as the hit on `ERR_INST`.

## Structure
- Shared defines go in `define/axi.vh`: `AXI_RESP_OKAY` (2'b00), `AXI_RESP_SLVERR`, `AXI_RESP_DECERR`, `AXI_ADDR_BUS`, `AXI_DATA_BUS`.
- Reuse `INST_ADDR_BUS` and `INST_DATA_BUS` from the global defines.
- Sub-module `ifetch_buf`: the one-entry buffer (valid/addr/data registers, fill port, hit compare).
- FSM and AXI drivers stay in the top module.
- Top-level SoC wiring:
  - Core `rom_*` pins connect to this bridge.
  - `stall_req_o` is ORed into the CTRL stall request that stalls PC and IF_ID.

## Test plan
- Reset, then `rom_ce_i = 1`, addr 0xBFC0_0000, slave zero-wait returning 0x3401_0001 -> `m_araddr = 0xBFC0_0000`, `stall_req_o` high for exactly 3 cycles, then `rom_data_o = 0x3401_0001`, stall low.
- Same request, slave delays `m_arready` by 2 and `m_rvalid` by 3 -> `m_arvalid`/`m_araddr` held stable throughout; stall lasts 8 cycles; correct data.
- Addr 0x0000_0006 -> `m_araddr = 0x0000_0004`. Repeated same PC for 5 cycles -> no new AR, stall low.
- Response `m_rresp = 2'b10` -> `rom_data_o = 0x0000_0000`, `fetch_err_o` pulses exactly 1 cycle.
- PC changes 0x100 -> 0x200 while in DATA -> the 0x100 fill completes, then a second AR to 0x200 is issued, and `rom_data_o` shows the 0x200 data.
- `rst` asserted while in ADDR -> next cycle `m_arvalid = 0`, `m_rready = 0`, buffer invalid. A fetch after reset re-issues the AR.
